calc_operand_datapath: RTL and testbench
========================================

Name: calc_operand_datapath

Overview:
- Datapath stage directly downstream of the calculator input-sequencing FSM.
- Consumes the FSM's trigger_1, trigger_2, trigger_op and estado outputs.
- Assembles two hex operands digit-by-digit from the switches, latches the operation code, computes a registered result and selects the value to drive the 7-segment display driver.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4. Maximum digits per operand is WIDTH/4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- trigger_1  input  1  one-cycle pulse: shift digit_in into operand 1
- trigger_2  input  1  one-cycle pulse: shift digit_in into operand 2
- trigger_op  input  1  level: high while FSM is in operation/result phase
- estado  input  2  FSM phase: 0 = op1, 1 = op2, 2 = operation, 3 = show result
- digit_in  input  4  hex digit from switches
- op_sel  input  2  operation code from switches
- op1  output  WIDTH  operand 1 register
- op2  output  WIDTH  operand 2 register
- result  output  WIDTH  registered result
- result_valid  output  1  result holds a valid computation
- overflow  output  1  carry/borrow/overflow flag for the current result
- display_value  output  WIDTH  value for the display driver

Behaviour:
- Reset (async, rst=1): op1=0, op2=0, result=0, result_valid=0, overflow=0, internal digit counters cnt1=cnt2=0, latched op=0, trigger_op_d=0.
- Digit entry, effective on the clock edge where the trigger is sampled high:
  - trigger_1 and cnt1<WIDTH/4: op1 <= {op1[WIDTH-5:0], digit_in}; cnt1++.
  - trigger_2 and cnt2<WIDTH/4: op2 <= {op2[WIDTH-5:0], digit_in}; cnt2++.
  - Counter saturated: the trigger is ignored; operand and counter are unchanged.
  - trigger_1 and trigger_2 high in the same cycle: only trigger_1 acts.
- Operation:
  - trigger_op_d is a registered copy of trigger_op.
  - On the rising edge of trigger_op (trigger_op=1, trigger_op_d=0), op_sel is latched.
  - result, overflow and result_valid=1 are written on the following clock edge, so result is available 2 cycles after trigger_op rises.
  - op_sel changes while trigger_op stays high are ignored.
- Op codes:
  - 00 ADD: result = (op1+op2) mod 2^WIDTH; overflow = carry out.
  - 01 SUB: result = (op1-op2) mod 2^WIDTH; overflow = (op1<op2), i.e. borrow.
  - 10 AND: result = op1 & op2; overflow = 0.
  - 11 OR: result = op1 | op2; overflow = 0.
- Falling edge of trigger_op, or a transition of estado from 3 to 0 (sequence restart):
  - Clear op1, op2, cnt1, cnt2, result, result_valid, overflow.
  - If both happen in the same cycle, the clear happens once.
- display_value is combinational from estado:
  - 0 → op1
  - 1 → op2
  - 2 → latched op code zero-extended
  - 3 → result
- Triggers arriving while trigger_op=1 are ignored, so operands are frozen during operation and result phases.
- Reset asserted mid-entry or mid-compute: immediate return to reset values; no partial write survives.

Optional Feature:
- Macro CALC_MUL_EN.
- Defined: op code 11 = MUL; result = low WIDTH bits of op1*op2; overflow = 1 if the upper WIDTH bits of the product are nonzero. Result latency is unchanged at 2 cycles.
- Undefined: op code 11 = OR as above; no multiplier is synthesized.

Test Plan:
- Reset, then trigger_1 pulses with digit_in=1,2,3,4 → op1=16'h1234, cnt1=4; a fifth trigger_1 with digit_in=F → op1 stays 16'h1234.
- op1=16'hFFFF, op2=16'h0001 (entered via trigger_2), op_sel=00, raise trigger_op → 2 cycles later result=16'h0000, overflow=1, result_valid=1.
- op1=16'h0003, op2=16'h0005, op_sel=01 → result=16'hFFFE, overflow=1; then change op_sel to 10 while trigger_op is high → result unchanged.
- trigger_1 and trigger_2 in the same cycle with digit_in=7, op1=op2=0 → op1=16'h0007, op2=16'h0000.
- estado sweep 0..3 with op1=16'hAAAA, op2=16'h5555, op=10 latched → display_value = AAAA, 5555, 0002, 0000 (AND result); estado 3→0 → op1=op2=result=0, result_valid=0.
- CALC_MUL_EN defined: op1=16'h0100, op2=16'h0100, op_sel=11 → result=16'h0000, overflow=1; undefined: same stimulus → result=16'h0100, overflow=0. Assert rst mid-entry after 2 digits → all outputs 0 immediately.

Source files
------------

// File: rtl/calc_operand_datapath.sv
// calc_operand_datapath: hex operand entry, op-code latch, registered ALU result and display select.
// Define CALC_MUL_EN to turn op code 11 into a multiply (low half result, high half nonzero flags overflow).
module calc_operand_datapath #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trigger_1,
   input  logic             trigger_2,
   input  logic             trigger_op,
   input  logic [1:0]       estado,
   input  logic [3:0]       digit_in,
   input  logic [1:0]       op_sel,
   output logic [WIDTH-1:0] op1,
   output logic [WIDTH-1:0] op2,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             overflow,
   output logic [WIDTH-1:0] display_value
);
   localparam int DIGITS = WIDTH / 4;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CMAX = CW'(DIGITS);

   logic [CW-1:0]    cnt1, cnt2;
   logic [1:0]       op_q, estado_d;
   logic             trigger_op_d, calc_pend;
   logic             op_rise, clr, load1, load2;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
`ifdef CALC_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod = op1 * op2;
`endif

   assign op_rise = trigger_op & ~trigger_op_d;
   // a falling trigger_op and a 3->0 restart in the same cycle share one clear
   assign clr     = (~trigger_op & trigger_op_d) | (estado_d == 2'd3 && estado == 2'd0);
   assign load1   = trigger_1 & ~trigger_op & (cnt1 < CMAX);
   assign load2   = trigger_2 & ~trigger_1 & ~trigger_op & (cnt2 < CMAX);
   assign sum     = {1'b0, op1} + {1'b0, op2};
   assign diff    = {1'b0, op1} - {1'b0, op2};

   always_comb begin
`ifdef CALC_MUL_EN
      alu_res = op_q == 2'd0 ? sum[WIDTH-1:0] : op_q == 2'd1 ? diff[WIDTH-1:0] :
                op_q == 2'd2 ? op1 & op2 : prod[WIDTH-1:0];
      alu_ovf = op_q == 2'd0 ? sum[WIDTH] : op_q == 2'd1 ? diff[WIDTH] :
                op_q == 2'd3 && |prod[2*WIDTH-1:WIDTH];
`else
      alu_res = op_q == 2'd0 ? sum[WIDTH-1:0] : op_q == 2'd1 ? diff[WIDTH-1:0] :
                op_q == 2'd2 ? op1 & op2 : op1 | op2;
      alu_ovf = op_q == 2'd0 ? sum[WIDTH] : op_q == 2'd1 && diff[WIDTH];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op1          <= '0;
         op2          <= '0;
         cnt1         <= '0;
         cnt2         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         op_q         <= 2'd0;
         trigger_op_d <= 1'b0;
         estado_d     <= 2'd0;
         calc_pend    <= 1'b0;
      end else begin
         trigger_op_d <= trigger_op;
         estado_d     <= estado;
         if (op_rise) op_q <= op_sel;
         if (clr) begin
            op1          <= '0;
            op2          <= '0;
            cnt1         <= '0;
            cnt2         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            calc_pend    <= 1'b0;
         end else begin
            calc_pend <= op_rise;
            if (calc_pend) begin
               result       <= alu_res;
               overflow     <= alu_ovf;
               result_valid <= 1'b1;
            end
            if (load1) begin
               op1  <= {op1[WIDTH-5:0], digit_in};
               cnt1 <= cnt1 + 1'b1;
            end
            if (load2) begin
               op2  <= {op2[WIDTH-5:0], digit_in};
               cnt2 <= cnt2 + 1'b1;
            end
         end
      end
   end

   assign display_value = estado == 2'd0 ? op1 : estado == 2'd1 ? op2 :
                          estado == 2'd2 ? {{(WIDTH-2){1'b0}}, op_q} : result;
endmodule

// File: tb/tb_calc_operand_datapath.sv
// tb_calc_operand_datapath: scoreboard bench with a behavioural calculator model and randomized entry.
module tb_calc_operand_datapath;
   logic clk = 0, rst = 1;
   logic trigger_1 = 0, trigger_2 = 0, trigger_op = 0;
   logic [1:0] estado = 0, op_sel = 0;
   logic [3:0] digit_in = 0;
   logic [15:0] op1, op2, result, display_value;
   logic result_valid, overflow;

   calc_operand_datapath #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .trigger_1(trigger_1), .trigger_2(trigger_2),
      .trigger_op(trigger_op), .estado(estado), .digit_in(digit_in), .op_sel(op_sel),
      .op1(op1), .op2(op2), .result(result), .result_valid(result_valid),
      .overflow(overflow), .display_value(display_value)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int m1 = 0, m2 = 0, c1 = 0, c2 = 0;
   logic [16:0] exp_q[$];
   logic rv_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) rv_prev = 0;
      else begin
         if (result_valid && !rv_prev) begin
            if (exp_q.size() == 0) chk("unexpected_result_valid", 1, 0);
            else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               chk("result", result, e[15:0]);
               chk("overflow", overflow, e[16]);
            end
         end
         rv_prev = result_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enter(input bit which, input logic [3:0] d);
      estado = which ? 2'd1 : 2'd0;
      digit_in = d;
      if (which) trigger_2 = 1; else trigger_1 = 1;
      tick();
      trigger_1 = 0;
      trigger_2 = 0;
      if (!which && c1 < 4) begin m1 = ((m1 * 16) + d) % 65536; c1++; end
      if (which && c2 < 4) begin m2 = ((m2 * 16) + d) % 65536; c2++; end
      chk(which ? "op2" : "op1", which ? op2 : op1, which ? m2 : m1);
      chk("display_entry", display_value, which ? m2 : m1);
   endtask

   task automatic compute(input logic [1:0] sel);
      longint r;
      logic ov;
      case (sel)
         2'd0: begin r = m1 + m2; ov = r > 65535; end
         2'd1: begin r = m1 - m2; ov = m1 < m2; end
         2'd2: begin r = m1 & m2; ov = 0; end
`ifdef CALC_MUL_EN
         default: begin r = longint'(m1) * m2; ov = (r >> 16) != 0; end
`else
         default: begin r = m1 | m2; ov = 0; end
`endif
      endcase
      r = r & 64'hFFFF;
      exp_q.push_back({ov, r[15:0]});
      estado = 2;
      op_sel = sel;
      trigger_op = 1;
      tick();
      chk("latency_rv_low", result_valid, 0);
      chk("display_op", display_value, {30'd0, sel});
      op_sel = 2'($urandom);
      digit_in = 4'($urandom);
      trigger_1 = 1'($urandom);
      trigger_2 = 1'($urandom);
      tick();
      trigger_1 = 0;
      trigger_2 = 0;
      chk("latency_rv_high", result_valid, 1);
      estado = 3;
      #1 chk("display_result", display_value, r[15:0]);
      tick();
      chk("result_hold", result, r[15:0]);
      chk("op1_frozen", op1, m1);
      chk("op2_frozen", op2, m2);
   endtask

   task automatic release_op();
      trigger_op = 0;
      estado = 0;
      tick();
      m1 = 0; m2 = 0; c1 = 0; c2 = 0;
      chk("clr_op1", op1, 0);
      chk("clr_op2", op2, 0);
      chk("clr_result", result, 0);
      chk("clr_rv", result_valid, 0);
      chk("clr_ovf", overflow, 0);
   endtask

   task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel);
      for (int i = 3; i >= 0; i--) enter(0, 4'(a >> (4 * i)));
      for (int i = 3; i >= 0; i--) enter(1, 4'(b >> (4 * i)));
      compute(sel);
      release_op();
   endtask

   task automatic reset_model();
      m1 = 0; m2 = 0; c1 = 0; c2 = 0;
      exp_q.delete();
   endtask

   initial begin
      tick();
      tick();
      chk("rst_op1", op1, 0);
      chk("rst_op2", op2, 0);
      chk("rst_result", result, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_display", display_value, 0);
      rst = 0;
      tick();
      enter(0, 1); enter(0, 2); enter(0, 3); enter(0, 4);
      enter(0, 4'hF);
      chk("op1_saturated", op1, 16'h1234);
      compute(2'($urandom));
      release_op();
      run(16'hFFFF, 16'h0001, 2'd0);
      run(16'h0003, 16'h0005, 2'd1);
      run(16'hAAAA, 16'h5555, 2'd2);
      run(16'h0100, 16'h0100, 2'd3);
      estado = 0;
      digit_in = 7;
      trigger_1 = 1;
      trigger_2 = 1;
      tick();
      trigger_1 = 0;
      trigger_2 = 0;
      m1 = 7; c1 = 1;
      chk("both_op1", op1, 16'h0007);
      chk("both_op2", op2, 16'h0000);
      estado = 3;
      tick();
      estado = 0;
      tick();
      reset_model();
      chk("restart_op1", op1, 0);
      for (int n = 0; n < 40; n++) begin
         int n1, n2;
         n1 = $urandom_range(0, 5);
         n2 = $urandom_range(0, 5);
         for (int i = 0; i < n1; i++) enter(0, 4'($urandom));
         for (int i = 0; i < n2; i++) enter(1, 4'($urandom));
         compute(2'($urandom));
         release_op();
      end
      enter(0, 4'h9); enter(0, 4'h8);
      @(posedge clk);
      #3 rst = 1;
      #1;
      chk("midrst_op1", op1, 0);
      chk("midrst_display", display_value, 0);
      tick();
      rst = 0;
      reset_model();
      enter(0, 4'h5);
      enter(1, 4'h6);
      estado = 2;
      op_sel = 0;
      trigger_op = 1;
      tick();
      #2 rst = 1;
      trigger_op = 0;
      #1;
      chk("midcalc_result", result, 0);
      chk("midcalc_rv", result_valid, 0);
      chk("midcalc_op2", op2, 0);
      tick();
      rst = 0;
      estado = 0;
      reset_model();
      tick();
      tick();
      tick();
      chk("no_spurious_rv", result_valid, 0);
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
